// File: rtl/mx_block_accum.sv
// rtl/mx_block_accum.sv - scales signed block dot products by E8M0 exponents and accumulates them
module mx_block_accum #(
  parameter int bit_width   = 8,
  parameter int k           = 32,
  parameter int dp_width    = 2*bit_width + $clog2(k),
  parameter int scale_width = 8,
  parameter int scale_bias  = 127,
  parameter int frac_bits   = 16,
  parameter int acc_width   = 48
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic signed [dp_width-1:0]  i_dp,
  input  logic [scale_width-1:0]      i_scale_a,
  input  logic [scale_width-1:0]      i_scale_b,
  input  logic                        i_last,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic signed [acc_width-1:0] o_acc,
  output logic                        o_nan,
  output logic                        o_valid,
  input  logic                        i_ready
);

  localparam int shw = scale_width + 3;
  localparam int ww  = acc_width + dp_width;
  localparam int sab = $clog2(acc_width);
  localparam int sdb = $clog2(dp_width);
  localparam logic [scale_width-1:0] nan_code = '1;
  localparam logic signed [acc_width-1:0] acc_max = {1'b0, {(acc_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] acc_min = {1'b1, {(acc_width-1){1'b0}}};

  typedef enum logic [1:0] {
    s_acc,
    s_drain,
    s_hold
  } state_t;

  state_t state, next_state;

  logic [shw-1:0]              sh;
  logic [shw-1:0]              nsh;
  logic signed [ww-1:0]        dp_ext;
  logic signed [ww-1:0]        shifted;
  logic [dp_width:0]           hi;
  logic                        in_nan;
  logic signed [acc_width-1:0] term;
  logic                        accept;

  logic                        s1_vld;
  logic                        s1_last;
  logic                        s1_nan;
  logic signed [acc_width-1:0] s1_term;

  logic signed [acc_width-1:0] acc;
  logic                        nan;
  logic signed [acc_width:0]   sum;
  logic signed [acc_width-1:0] sum_sat;

  // sh is treated as a two's-complement value; its MSB selects the shift direction
  always_comb begin
    sh      = shw'(i_scale_a) + shw'(i_scale_b) - shw'(2*scale_bias - frac_bits);
    nsh     = -sh;
    dp_ext  = {{acc_width{i_dp[dp_width-1]}}, i_dp};
    shifted = '0;
    hi      = '0;
    in_nan  = (i_scale_a == nan_code) || (i_scale_b == nan_code);
    term    = '0;
    if (in_nan || (i_dp == '0)) begin
      term = '0;
    end else if (!sh[shw-1]) begin
      if (sh >= shw'(acc_width)) begin
        term = i_dp[dp_width-1] ? acc_min : acc_max;
      end else begin
        shifted = dp_ext <<< sh[sab-1:0];
        hi      = shifted[ww-1:acc_width-1];
        if ((&hi) || !(|hi)) begin
          term = shifted[acc_width-1:0];
        end else begin
          term = i_dp[dp_width-1] ? acc_min : acc_max;
        end
      end
    end else if (nsh >= shw'(dp_width)) begin
      term = i_dp[dp_width-1] ? '1 : '0;
    end else begin
      shifted = dp_ext >>> nsh[sdb-1:0];
      term    = shifted[acc_width-1:0];
    end
  end

  always_comb begin
    sum     = {acc[acc_width-1], acc} + {s1_term[acc_width-1], s1_term};
    sum_sat = sum[acc_width-1:0];
    if (sum[acc_width] != sum[acc_width-1]) begin
      sum_sat = sum[acc_width] ? acc_min : acc_max;
    end
  end

  always_comb begin
    next_state = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      s_acc: begin
        o_ready = 1'b1;
        if (i_valid && i_last) begin
          next_state = s_drain;
        end
      end
      s_drain: begin
        if (s1_vld && s1_last) begin
          next_state = s_hold;
        end
      end
      s_hold: begin
        o_valid = 1'b1;
        if (i_ready) begin
          next_state = s_acc;
        end
      end
      default: next_state = s_acc;
    endcase
  end

  assign accept = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= s_acc;
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_nan  <= 1'b0;
      s1_term <= '0;
      acc     <= '0;
      nan     <= 1'b0;
    end else begin
      state  <= next_state;
      s1_vld <= accept;
      if (accept) begin
        s1_term <= term;
        s1_last <= i_last;
        s1_nan  <= in_nan;
      end
      // the handshake edge clears the sum so the next beat starts from zero
      if ((state == s_hold) && i_ready) begin
        acc <= '0;
        nan <= 1'b0;
      end else if (s1_vld) begin
        acc <= sum_sat;
        nan <= nan | s1_nan;
      end
    end
  end

  assign o_acc = acc;
  assign o_nan = nan;

endmodule

// File: tb/tb_mx_block_accum.sv
// tb/tb_mx_block_accum.sv - directed self-checking bench for mx_block_accum
module tb_mx_block_accum;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic signed [20:0] i_dp;
  logic [7:0]         i_scale_a;
  logic [7:0]         i_scale_b;
  logic               i_last;
  logic               i_valid;
  logic               o_ready;
  logic signed [47:0] o_acc;
  logic               o_nan;
  logic               o_valid;
  logic               i_ready;

  int vectors = 0;
  int errors  = 0;

  localparam logic signed [63:0] pos_max = 64'sd140737488355327;
  localparam logic signed [63:0] neg_max = -64'sd140737488355328;

  mx_block_accum dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_dp      (i_dp),
    .i_scale_a (i_scale_a),
    .i_scale_b (i_scale_b),
    .i_last    (i_last),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_acc     (o_acc),
    .o_nan     (o_nan),
    .o_valid   (o_valid),
    .i_ready   (i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic beat(input logic signed [20:0] dp, input logic [7:0] sa, input logic [7:0] sb,
                      input logic last);
    bit ok;
    i_dp = dp; i_scale_a = sa; i_scale_b = sb; i_last = last; i_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      ok = o_ready;
      tick();
      if (ok) break;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    chk("accept", 64'(ok), 64'sd1);
  endtask

  task automatic result(input string tag, input logic signed [63:0] exp_acc, input logic exp_nan,
                        input int hold_cycles);
    int n;
    chk({tag, "_drain_ready"}, 64'(o_ready), 64'sd0);
    chk({tag, "_drain_valid"}, 64'(o_valid), 64'sd0);
    n = 0;
    while (!o_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'sd1);
    chk({tag, "_acc"}, o_acc, exp_acc);
    chk({tag, "_nan"}, 64'(o_nan), 64'(exp_nan));
    chk({tag, "_hold_ready"}, 64'(o_ready), 64'sd0);
    for (int c = 0; c < hold_cycles; c++) begin
      i_valid = 1'b1;
      tick();
      chk({tag, "_stable_acc"}, o_acc, exp_acc);
      chk({tag, "_stable_valid"}, 64'(o_valid), 64'sd1);
      chk({tag, "_stable_ready"}, 64'(o_ready), 64'sd0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({tag, "_done_valid"}, 64'(o_valid), 64'sd0);
    chk({tag, "_done_ready"}, 64'(o_ready), 64'sd1);
    chk({tag, "_done_acc"}, o_acc, 64'sd0);
    chk({tag, "_done_nan"}, 64'(o_nan), 64'sd0);
  endtask

  initial begin
    i_rst = 1'b1; i_dp = '0; i_scale_a = '0; i_scale_b = '0;
    i_last = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
    chk("rst_acc", o_acc, 64'sd0);
    chk("rst_nan", 64'(o_nan), 64'sd0);
    chk("rst_valid", 64'(o_valid), 64'sd0);
    chk("rst_ready", 64'(o_ready), 64'sd1);

    beat(21'sd100, 8'd127, 8'd127, 1'b1);
    result("single", 64'sd6553600, 1'b0, 0);

    beat(21'sd1, 8'd127, 8'd127, 1'b0);
    chk("b2b_ready1", 64'(o_ready), 64'sd1);
    beat(-21'sd2, 8'd127, 8'd127, 1'b0);
    beat(21'sd3, 8'd127, 8'd127, 1'b0);
    beat(21'sd4, 8'd127, 8'd127, 1'b1);
    result("b2b", 64'sd393216, 1'b0, 0);

    beat(-21'sd1024, 8'd120, 8'd127, 1'b0);
    beat(-21'sd1024, 8'd100, 8'd100, 1'b0);
    beat(-21'sd1024, 8'd102, 8'd127, 1'b0);
    beat(-21'sd1025, 8'd102, 8'd127, 1'b1);
    result("shift", -64'sd524294, 1'b0, 0);

    beat(21'sd5, 8'd200, 8'd200, 1'b1);
    result("satpos", pos_max, 1'b0, 0);
    beat(-21'sd5, 8'd200, 8'd200, 1'b1);
    result("satneg", neg_max, 1'b0, 0);

    beat(21'sd1, 8'd143, 8'd142, 1'b1);
    result("bit47", pos_max, 1'b0, 0);
    beat(-21'sd1, 8'd143, 8'd142, 1'b1);
    result("neg47", neg_max, 1'b0, 0);

    beat(21'sd1, 8'd142, 8'd142, 1'b0);
    beat(21'sd1, 8'd142, 8'd142, 1'b1);
    result("accsat", pos_max, 1'b0, 0);

    beat(21'sd0, 8'd200, 8'd200, 1'b1);
    result("zero", 64'sd0, 1'b0, 0);

    beat(21'sd7, 8'd127, 8'd127, 1'b0);
    beat(21'sd9, 8'd255, 8'd127, 1'b0);
    beat(21'sd11, 8'd127, 8'd127, 1'b1);
    result("nan", 64'sd1179648, 1'b1, 0);
    beat(21'sd1, 8'd127, 8'd127, 1'b1);
    result("nanclr", 64'sd65536, 1'b0, 0);

    beat(21'sd3, 8'd127, 8'd127, 1'b1);
    result("hold", 64'sd196608, 1'b0, 5);

    beat(21'sd50, 8'd127, 8'd127, 1'b0);
    beat(21'sd60, 8'd127, 8'd127, 1'b0);
    chk("partial_acc", o_acc, 64'sd3276800);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("midrst_acc", o_acc, 64'sd0);
    chk("midrst_nan", 64'(o_nan), 64'sd0);
    chk("midrst_valid", 64'(o_valid), 64'sd0);
    chk("midrst_ready", 64'(o_ready), 64'sd1);
    tick();
    chk("midrst_flush", o_acc, 64'sd0);
    beat(21'sd2, 8'd127, 8'd127, 1'b1);
    result("postrst", 64'sd131072, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
